// File: rtl/a1339_multi_reader.sv
// Round-robin poller for up to 16 A1339 angle sensors on one SPI master.
// Tracks multi-turn position, averages samples and keeps per-sensor error counts.
module a1339_multi_reader #(
    parameter int          NUMBER_OF_SENSORS = 4,
    parameter int          AVG_LOG2          = 3,
    parameter int          TIMEOUT_CYCLES    = 4096,
    parameter logic [19:0] ANGLE_CMD         = 20'h20009,
    parameter logic [19:0] TURNS_CMD         = 20'h2C001
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUMBER_OF_SENSORS-1:0] sensor_enable,
    input  logic                         zero_offset,
    input  logic [3:0]                   sensor_sel,
    output logic [31:0]                  rd_angle_raw,
    output logic [31:0]                  rd_angle_abs,
    output logic [31:0]                  rd_rev_counter,
    output logic [15:0]                  rd_crc_errors,
    output logic [15:0]                  rd_timeouts,
    output logic                         update_valid,
    output logic [3:0]                   update_sensor,
    output logic [19:0]                  spi_di,
    output logic                         spi_wren,
    input  logic                         spi_do_valid,
    input  logic [19:0]                  spi_do,
    output logic [NUMBER_OF_SENSORS-1:0] spi_ss_n,
    input  logic                         spi_ssel
);

    localparam int N  = NUMBER_OF_SENSORS;
    localparam int CW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] NAVG = CW'(2 ** AVG_LOG2);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_NEXT, S_CMD, S_WAIT_CMD,
        S_DATA, S_WAIT_DATA, S_CHECK, S_UPDATE
    } state_t;

    state_t state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [19:0]   di_q, di_d;
    logic          turns_q, turns_d;
    logic [19:0]   data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [11:0] raw_q [N];
    logic [11:0] raw_d [N];
    logic [11:0] prev_q [N];
    logic [11:0] prev_d [N];
    logic [31:0] trn_q [N];
    logic [31:0] trn_d [N];
    logic [31:0] off_q [N];
    logic [31:0] off_d [N];
    logic [31:0] acc_q [N];
    logic [31:0] acc_d [N];
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [31:0] abs_q [N];
    logic [31:0] abs_d [N];
    logic [15:0] crc_q [N];
    logic [15:0] crc_d [N];
    logic [15:0] to_q [N];
    logic [15:0] to_d [N];
    logic [N-1:0] init_q, init_d;

    function automatic logic [3:0] crc4(input logic [15:0] d);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 15; i >= 0; i--)
            c = {c[2:0], 1'b0} ^ ((c[3] ^ d[i]) ? 4'h3 : 4'h0);
        return c;
    endfunction

    // Next enabled sensor after the current one, wrapping around
    logic        found;
    logic [3:0]  nxt_idx;
    logic        nxt_init;
    logic [4:0]  sj;
    logic [15:0] en_ext;
    logic [15:0] init_ext;

    always_comb begin
        found    = 1'b0;
        nxt_idx  = idx_q;
        sj       = '0;
        en_ext   = 16'(sensor_enable);
        init_ext = 16'(init_q);
        for (int i = 1; i <= N; i++) begin
            sj = {1'b0, idx_q} + 5'(i);
            if (sj >= 5'(N))
                sj = sj - 5'(N);
            if (!found && en_ext[sj[3:0]]) begin
                found   = 1'b1;
                nxt_idx = sj[3:0];
            end
        end
        nxt_init = init_ext[nxt_idx];
    end

    logic [15:0]        dat;
    logic [11:0]        raw;
    logic               crc_ok;
    logic               waiting;
    logic               timeout;
    logic [31:0]        cur_trn;
    logic [11:0]        cur_prev;
    logic [31:0]        cur_off;
    logic [31:0]        cur_acc;
    logic [CW-1:0]      cur_cnt;
    logic signed [12:0] delta;
    logic [31:0]        new_trn;
    logic [31:0]        sample;
    logic signed [31:0] acc_sum;
    logic [CW-1:0]      cnt_inc;
    logic               publish;

    assign dat    = data_q[19:4];
    assign raw    = dat[11:0];
    assign crc_ok = crc4(dat) == data_q[3:0];

    always_comb begin
        cur_trn  = '0;
        cur_prev = '0;
        cur_off  = '0;
        cur_acc  = '0;
        cur_cnt  = '0;
        for (int k = 0; k < N; k++) begin
            if (4'(k) == idx_q) begin
                cur_trn  = trn_q[k];
                cur_prev = prev_q[k];
                cur_off  = off_q[k];
                cur_acc  = acc_q[k];
                cur_cnt  = cnt_q[k];
            end
        end
        delta = $signed({1'b0, raw}) - $signed({1'b0, cur_prev});
        if (delta > 13'sd2047)
            new_trn = cur_trn - 32'd1;
        else if (delta < -13'sd2048)
            new_trn = cur_trn + 32'd1;
        else
            new_trn = cur_trn;
        sample  = {new_trn[19:0], 12'h000} + {20'h0, raw} - cur_off;
        acc_sum = $signed(cur_acc + sample);
        cnt_inc = cur_cnt + CW'(1);
        publish = cnt_inc == NAVG;
    end

    assign waiting = (state_q == S_WAIT_CMD) || (state_q == S_WAIT_DATA);
    assign timeout = waiting && !spi_do_valid && (tmo_q == TMAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (|sensor_enable) state_d = S_NEXT;
            S_NEXT:      state_d = found ? S_CMD : S_IDLE;
            S_CMD:       state_d = S_WAIT_CMD;
            S_WAIT_CMD:
                if (spi_do_valid)  state_d = S_DATA;
                else if (timeout)  state_d = S_NEXT;
            S_DATA:      state_d = S_WAIT_DATA;
            S_WAIT_DATA:
                if (spi_do_valid)  state_d = S_CHECK;
                else if (timeout)  state_d = S_NEXT;
            S_CHECK:     state_d = crc_ok ? S_UPDATE : S_NEXT;
            S_UPDATE:    state_d = S_NEXT;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        spi_wren      = (state_q == S_CMD) || (state_q == S_DATA);
        update_valid  = (state_q == S_UPDATE) && !turns_q && publish;
        update_sensor = idx_q;
        spi_di        = di_q;
        for (int k = 0; k < N; k++)
            spi_ss_n[k] = (waiting || spi_wren) && (4'(k) == idx_q)
                          ? spi_ssel : 1'b1;
    end

    always_comb begin
        idx_d   = idx_q;
        di_d    = di_q;
        turns_d = turns_q;
        data_d  = data_q;
        tmo_d   = waiting ? tmo_q + TW'(1) : '0;
        if (state_q == S_NEXT && found) begin
            idx_d   = nxt_idx;
            turns_d = !nxt_init;
            di_d    = nxt_init ? ANGLE_CMD : TURNS_CMD;
        end
        if (state_q == S_WAIT_DATA && spi_do_valid)
            data_d = spi_do;
    end

    always_comb begin
        init_d = init_q;
        for (int k = 0; k < N; k++) begin
            raw_d[k]  = raw_q[k];
            prev_d[k] = prev_q[k];
            trn_d[k]  = trn_q[k];
            off_d[k]  = off_q[k];
            acc_d[k]  = acc_q[k];
            cnt_d[k]  = cnt_q[k];
            abs_d[k]  = abs_q[k];
            crc_d[k]  = crc_q[k];
            to_d[k]   = to_q[k];
        end
        for (int k = 0; k < N; k++) begin
            if (4'(k) == idx_q) begin
                if (state_q == S_UPDATE && turns_q) begin
                    trn_d[k]  = {{20{raw[11]}}, raw};
                    prev_d[k] = '0;
                    init_d[k] = 1'b1;
                end
                if (state_q == S_UPDATE && !turns_q) begin
                    trn_d[k]  = new_trn;
                    prev_d[k] = raw;
                    raw_d[k]  = raw;
                    if (publish) begin
                        abs_d[k] = 32'(acc_sum >>> AVG_LOG2);
                        acc_d[k] = '0;
                        cnt_d[k] = '0;
                    end else begin
                        acc_d[k] = acc_sum;
                        cnt_d[k] = cnt_inc;
                    end
                end
                if (state_q == S_CHECK && !crc_ok && crc_q[k] != 16'hFFFF)
                    crc_d[k] = crc_q[k] + 16'd1;
                if (timeout) begin
                    init_d[k] = 1'b0;
                    if (to_q[k] != 16'hFFFF)
                        to_d[k] = to_q[k] + 16'd1;
                end
            end
            // Zeroing sees this cycle's freshly tracked turns/prev
            if (zero_offset) begin
                off_d[k] = {trn_d[k][19:0], 12'h000} + {20'h0, prev_d[k]};
                acc_d[k] = '0;
                cnt_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            di_q    <= '0;
            turns_q <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
            init_q  <= '0;
            for (int k = 0; k < N; k++) begin
                raw_q[k]  <= '0;
                prev_q[k] <= '0;
                trn_q[k]  <= '0;
                off_q[k]  <= '0;
                acc_q[k]  <= '0;
                cnt_q[k]  <= '0;
                abs_q[k]  <= '0;
                crc_q[k]  <= '0;
                to_q[k]   <= '0;
            end
        end else begin
            idx_q   <= idx_d;
            di_q    <= di_d;
            turns_q <= turns_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            init_q  <= init_d;
            for (int k = 0; k < N; k++) begin
                raw_q[k]  <= raw_d[k];
                prev_q[k] <= prev_d[k];
                trn_q[k]  <= trn_d[k];
                off_q[k]  <= off_d[k];
                acc_q[k]  <= acc_d[k];
                cnt_q[k]  <= cnt_d[k];
                abs_q[k]  <= abs_d[k];
                crc_q[k]  <= crc_d[k];
                to_q[k]   <= to_d[k];
            end
        end
    end

    always_comb begin
        rd_angle_raw   = '0;
        rd_angle_abs   = '0;
        rd_rev_counter = '0;
        rd_crc_errors  = '0;
        rd_timeouts    = '0;
        for (int k = 0; k < N; k++) begin
            if (4'(k) == sensor_sel) begin
                rd_angle_raw   = {20'h0, raw_q[k]};
                rd_angle_abs   = abs_q[k];
                rd_rev_counter = trn_q[k];
                rd_crc_errors  = crc_q[k];
                rd_timeouts    = to_q[k];
            end
        end
    end

endmodule

// File: tb/tb_a1339_multi_reader.sv
// Bench for a1339_multi_reader: scripted sensor responder plus
// directed phases covering tracking, CRC, timeout, masking and zeroing.
module tb_a1339_multi_reader;

    localparam logic [19:0] ANGLE = 20'h20009;
    localparam logic [19:0] TURNS = 20'h2C001;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  sensor_enable;
    logic        zero_offset;
    logic [3:0]  sensor_sel;
    logic [31:0] rd_angle_raw;
    logic [31:0] rd_angle_abs;
    logic [31:0] rd_rev_counter;
    logic [15:0] rd_crc_errors;
    logic [15:0] rd_timeouts;
    logic        update_valid;
    logic [3:0]  update_sensor;
    logic [19:0] spi_di;
    logic        spi_wren;
    logic        spi_do_valid;
    logic [19:0] spi_do;
    logic [3:0]  spi_ss_n;
    logic        spi_ssel;

    a1339_multi_reader dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .sensor_enable  (sensor_enable),
        .zero_offset    (zero_offset),
        .sensor_sel     (sensor_sel),
        .rd_angle_raw   (rd_angle_raw),
        .rd_angle_abs   (rd_angle_abs),
        .rd_rev_counter (rd_rev_counter),
        .rd_crc_errors  (rd_crc_errors),
        .rd_timeouts    (rd_timeouts),
        .update_valid   (update_valid),
        .update_sensor  (update_sensor),
        .spi_di         (spi_di),
        .spi_wren       (spi_wren),
        .spi_do_valid   (spi_do_valid),
        .spi_do         (spi_do),
        .spi_ss_n       (spi_ss_n),
        .spi_ssel       (spi_ssel)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        resp;
        logic [19:0] frame;
    } resp_t;

    typedef struct packed {
        logic [19:0] cmd;
        logic [3:0]  ss;
    } log_t;

    typedef struct packed {
        logic [11:0] raw;
        logic [31:0] exp_rev;
    } vec_t;

    resp_t rq[$];
    log_t  lg[$];
    vec_t  tv[5];

    int   checks = 0;
    int   errs   = 0;
    int   cyc    = 0;
    int   vcyc   = 0;
    int   upd_cnt = 0;
    int   upd_lat = 0;
    logic [3:0] upd_sen = '0;
    logic [3:0] ss_seen = '0;
    logic busy = 1'b0;

    function automatic logic [3:0] bcrc(input logic [15:0] d);
        logic [3:0] c;
        logic fb;
        c = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c = c << 1;
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

    task automatic push_read(input logic [15:0] d, input logic bad);
        rq.push_back({1'b1, 20'h00000});
        rq.push_back({1'b1, d, bcrc(d) ^ (bad ? 4'h1 : 4'h0)});
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sel(input logic [3:0] s);
        sensor_sel = s;
        #1;
    endtask

    task automatic run(input logic [3:0] mask, input int budget);
        int n;
        n = 0;
        sensor_enable = mask;
        @(negedge clock);
        while ((rq.size() > 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        sensor_enable = '0;
        checks++;
        if (n >= budget) begin
            errs++;
            $display("FAIL run_budget: got %0d cycles expected < %0d",
                     n, budget);
        end
        repeat (10) @(negedge clock);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Sensor side: answers each write strobe from the response queue
    initial begin
        resp_t r;
        spi_do_valid = 1'b0;
        spi_do = '0;
        spi_ssel = 1'b1;
        forever begin
            @(negedge clock);
            while (spi_wren) begin
                busy = 1'b1;
                spi_ssel = 1'b0;
                @(negedge clock);
                lg.push_back({spi_di, spi_ss_n});
                @(negedge clock);
                if (rq.size() > 0) r = rq.pop_front();
                else r = '0;
                if (r.resp) begin
                    spi_do = r.frame;
                    spi_do_valid = 1'b1;
                    vcyc = cyc;
                    @(negedge clock);
                    spi_do_valid = 1'b0;
                end
                spi_ssel = 1'b1;
                busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (update_valid) begin
                upd_cnt++;
                upd_sen = update_sensor;
                upd_lat = cyc - vcyc;
            end
            ss_seen = ss_seen | ~spi_ss_n;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = {12'd2000, 32'd3};
        tv[1] = {12'd3500, 32'd3};
        tv[2] = {12'd4090, 32'd3};
        tv[3] = {12'd5,    32'd4};
        tv[4] = {12'd4090, 32'd3};

        reset_n = 1'b0;
        sensor_enable = '0;
        zero_offset = 1'b0;
        sensor_sel = '0;
        repeat (3) @(negedge clock);
        sel(0);
        chk("rst_ss_n", 32'(spi_ss_n), 32'hF);
        chk("rst_wren", 32'(spi_wren), 0);
        chk("rst_di", 32'(spi_di), 0);
        chk("rst_upd", 32'(update_valid), 0);
        chk("rst_upd_sensor", 32'(update_sensor), 0);
        chk("rst_abs", rd_angle_abs, 0);
        reset_n = 1'b1;

        lg.delete();
        push_read(16'h0003, 1'b0);
        for (int i = 0; i < 8; i++) push_read(16'h0100, 1'b0);
        run(4'b0001, 3000);
        chk("p1_first_cmd", 32'(lg[0].cmd), 32'(TURNS));
        chk("p1_first_ss", 32'(lg[0].ss), 32'hE);
        chk("p1_angle_cmd", 32'(lg[2].cmd), 32'(ANGLE));
        chk("p1_upd_cnt", upd_cnt, 1);
        chk("p1_upd_sensor", 32'(upd_sen), 0);
        chk("p1_upd_latency", upd_lat, 2);
        sel(0);
        chk("p1_abs", rd_angle_abs, 32'd12544);
        chk("p1_rev", rd_rev_counter, 32'd3);
        chk("p1_raw", rd_angle_raw, 32'h100);

        for (int i = 0; i < 5; i++) begin
            push_read({4'h0, tv[i].raw}, 1'b0);
            run(4'b0001, 500);
            sel(0);
            chk($sformatf("trk%0d_rev", i), rd_rev_counter, tv[i].exp_rev);
            chk($sformatf("trk%0d_raw", i), rd_angle_raw, 32'(tv[i].raw));
        end
        chk("trk_no_publish", upd_cnt, 1);

        lg.delete();
        push_read(16'h0000, 1'b1);
        push_read(16'd4000, 1'b0);
        run(4'b0011, 1000);
        chk("crc_log_size", lg.size(), 4);
        chk("crc_cmd0", 32'(lg[0].cmd), 32'(TURNS));
        chk("crc_ss0", 32'(lg[0].ss), 32'hD);
        chk("crc_cmd1", 32'(lg[2].cmd), 32'(ANGLE));
        chk("crc_ss1", 32'(lg[2].ss), 32'hE);
        sel(1);
        chk("crc_err_s1", 32'(rd_crc_errors), 1);
        chk("crc_rev_s1", rd_rev_counter, 0);
        sel(0);
        chk("crc_err_s0", 32'(rd_crc_errors), 0);
        chk("crc_raw_s0", rd_angle_raw, 32'd4000);
        chk("crc_upd_cnt", upd_cnt, 1);

        lg.delete();
        rq.push_back({1'b0, 20'h00000});
        push_read(16'h0000, 1'b0);
        run(4'b0001, 20000);
        chk("to_cmd0", 32'(lg[0].cmd), 32'(ANGLE));
        chk("to_cmd1", 32'(lg[1].cmd), 32'(TURNS));
        sel(0);
        chk("to_cnt_s0", 32'(rd_timeouts), 1);
        chk("to_rev_s0", rd_rev_counter, 0);
        sel(1);
        chk("to_cnt_s1", 32'(rd_timeouts), 0);

        push_read(16'h0200, 1'b0);
        run(4'b0001, 500);
        chk("z_pre_upd_cnt", upd_cnt, 1);
        zero_offset = 1'b1;
        @(negedge clock);
        zero_offset = 1'b0;
        for (int i = 0; i < 8; i++) push_read(16'h0200, 1'b0);
        run(4'b0001, 3000);
        chk("z_upd_cnt", upd_cnt, 2);
        sel(0);
        chk("z_abs", rd_angle_abs, 0);
        chk("z_raw", rd_angle_raw, 32'h200);

        lg.delete();
        ss_seen = '0;
        push_read(16'h0001, 1'b0);
        push_read(16'h0FFF, 1'b0);
        push_read(16'h0010, 1'b0);
        push_read(16'h0020, 1'b0);
        run(4'b1010, 2000);
        chk("m_ss0", 32'({lg[0].ss, lg[0].cmd}), 32'({4'hD, TURNS}));
        chk("m_ss1", 32'({lg[2].ss, lg[2].cmd}), 32'({4'h7, TURNS}));
        chk("m_ss2", 32'({lg[4].ss, lg[4].cmd}), 32'({4'hD, ANGLE}));
        chk("m_ss3", 32'({lg[6].ss, lg[6].cmd}), 32'({4'h7, ANGLE}));
        chk("m_ss_seen", 32'(ss_seen), 32'hA);
        sel(1);
        chk("m_rev_s1", rd_rev_counter, 32'd1);
        chk("m_raw_s1", rd_angle_raw, 32'h010);
        sel(3);
        chk("m_rev_s3", rd_rev_counter, 32'hFFFF_FFFF);
        chk("m_raw_s3", rd_angle_raw, 32'h020);
        sel(5);
        chk("sel_oob", rd_rev_counter | rd_angle_raw, 0);

        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst2_ss_n", 32'(spi_ss_n), 32'hF);
        sel(1);
        chk("rst2_crc_s1", 32'(rd_crc_errors), 0);
        sel(3);
        chk("rst2_rev_s3", rd_rev_counter, 0);
        sel(0);
        chk("rst2_to_s0", 32'(rd_timeouts), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/a1339_multi_reader.md
# a1339_multi_reader

Round-robin poller for up to 16 A1339 magnetic angle sensors sharing one SPI master. It replaces the single-sensor-at-a-time angle reader with per-sensor enable, CRC-checked frames, SPI timeout recovery, wrap-aware multi-turn tracking and per-sensor error statistics. It sits between the 20-bit `spi_master` and the Avalon register bank, which reads results through an indexed read port.

## Interface
- `NUMBER_OF_SENSORS`, 4: channels, 1..16.
- `AVG_LOG2`, 3: averages 2^AVG_LOG2 samples per published value, 0..9.
- `TIMEOUT_CYCLES`, 4096: max clocks waiting for `spi_do_valid`.
- `ANGLE_CMD`, 20'h20009: angle read frame.
- `TURNS_CMD`, 20'h2C001: turns read frame.

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `sensor_enable` in NUMBER_OF_SENSORS: poll mask.
- `zero_offset` in 1: pulse, captures offsets.
- `sensor_sel` in 4: read-port index.
- `rd_angle_raw` out 32: last 12-bit raw angle, zero-extended.
- `rd_angle_abs` out 32: signed, turns*4096+raw−offset, averaged.
- `rd_rev_counter` out 32: signed turns.
- `rd_crc_errors` out 16: saturating count.
- `rd_timeouts` out 16: saturating count.
- `update_valid` out 1: one-cycle pulse when `rd_*` storage for `update_sensor` changes.
- `update_sensor` out 4: channel just updated.
- `spi_di` out 20: frame to send.
- `spi_wren` out 1: one-cycle write strobe.
- `spi_do_valid` in 1: frame complete.
- `spi_do` in 20: received frame.
- `spi_ss_n` out NUMBER_OF_SENSORS: per-sensor select; only the current sensor follows `spi_ssel`.
- `spi_ssel` in 1: master's select.

## Operation
- Frames: data = `spi_do[19:4]`, CRC = `spi_do[3:0]`. CRC4 uses poly x^4+x+1, seed 4'hF, processed MSB first over 16 bits. Angle = data[11:0]; turns = data[11:0] sign-extended.
- The sensor answers the previous frame, so each read is two frames with the same command. Only the second response is used.
- FSM states: IDLE, NEXT, CMD, WAIT_CMD, DATA, WAIT_DATA, CHECK, UPDATE.
  - IDLE → NEXT when any `sensor_enable` bit is set.
  - NEXT advances the index to the next enabled sensor, wrapping from NUMBER_OF_SENSORS−1 to 0. It issues TURNS_CMD if that sensor's `init` flag is clear, else ANGLE_CMD. If the mask is empty, NEXT → IDLE.
  - CMD pulses `spi_wren` → WAIT_CMD.
  - WAIT_CMD → DATA on `spi_do_valid`.
  - DATA pulses `spi_wren` → WAIT_DATA.
  - WAIT_DATA → CHECK on `spi_do_valid`.
  - CHECK → UPDATE on CRC match. On mismatch it increments the crc counter and goes → NEXT.
  - UPDATE → NEXT.
- Timeout: in WAIT_CMD or WAIT_DATA, after TIMEOUT_CYCLES clocks without `spi_do_valid`, increment the timeout counter, clear the sensor's `init` flag and go → NEXT.
- UPDATE for a turns frame: load turns, store `prev` = 0 and set `init`. No publish and no `update_valid`.
- UPDATE for an angle frame:
  - delta = raw − prev as a 13-bit signed value.
  - If delta > 2047, turns−1; if delta < −2048, turns+1.
  - Set prev = raw.
  - Add turns*4096+raw−offset to the 32-bit accumulator and increment the sample count.
  - When the count reaches 2^AVG_LOG2, publish accumulator>>>AVG_LOG2, clear accumulator and count, and pulse `update_valid`.
- `rd_rev_counter` and `rd_angle_raw` update on every valid angle frame.
- `zero_offset` sets offset[k] = turns[k]*4096+prev[k] for all k. If it coincides with UPDATE, the newly computed values are used. The accumulator is cleared and the sample count reset.
- Counters saturate at 16'hFFFF and clear only on reset.
- A disabled sensor keeps its stored values.

## Timing
- Reset values:
  - all registers 0, `init` flags clear;
  - `spi_ss_n` all ones, `spi_wren` 0, `spi_di` 0;
  - `update_valid` 0, `update_sensor` 0.
- Read port is combinational from `sensor_sel`; values ≥ NUMBER_OF_SENSORS return 0.
- `update_valid` asserts 2 clocks after the data-frame `spi_do_valid`.
- `spi_di` is stable from the `spi_wren` cycle until the next `spi_do_valid`.
- Reset mid-frame aborts immediately: SS deasserts and the sensor is re-initialised with TURNS_CMD.

## Test plan
- Reset, 1 sensor enabled, turns frame data 16'h0003 with valid CRC, then 8 angle frames of 12'h100 → one `update_valid` with `rd_angle_abs` = 12544 and `rd_rev_counter` = 3.
- Angle sequence 4090, 5 → turns increments to 4. Sequence 5, 4090 → turns decrements back.
- Corrupt CRC on one frame → `rd_crc_errors` = 1, no update, polling continues with the next sensor.
- Hold `spi_do_valid` low TIMEOUT_CYCLES → `rd_timeouts` = 1. The next visit to that sensor sends TURNS_CMD.
- Enable mask 4'b1010 → only SS bits 1 and 3 toggle, visited alternately.
- `zero_offset` at steady angle 12'h200, turns 0 → subsequent published `rd_angle_abs` = 0.
